// File: rtl/vtg_pkg.sv
// Shared timing defaults, counter widths, pattern selector encoding and the colour-bar table
// for the 720p video timing generator.
package vtg_pkg;

   localparam int H_ACTIVE_D = 1280;
   localparam int H_FP_D     = 110;
   localparam int H_SYNC_D   = 40;
   localparam int H_BP_D     = 220;
   localparam int V_ACTIVE_D = 720;
   localparam int V_FP_D     = 5;
   localparam int V_SYNC_D   = 5;
   localparam int V_BP_D     = 20;

   localparam int H_TOTAL = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int V_TOTAL = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

   localparam int HCW = 11;
   localparam int VCW = 10;

   typedef enum logic [1:0] {
      PAT_EXT   = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_RAMP  = 2'd2,
      PAT_WHITE = 2'd3
   } pat_e;

   // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      logic [23:0] rgb;
      case (idx)
         3'd0:    rgb = 24'hFFFFFF;
         3'd1:    rgb = 24'hFFFF00;
         3'd2:    rgb = 24'h00FFFF;
         3'd3:    rgb = 24'h00FF00;
         3'd4:    rgb = 24'hFF00FF;
         3'd5:    rgb = 24'hFF0000;
         3'd6:    rgb = 24'h0000FF;
         default: rgb = 24'h000000;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/vtg_pattern.sv
// Internal test-pattern source: column + pattern select to RGB with one register stage,
// so it lines up with the external store's 1-cycle read latency.
module vtg_pattern
   import vtg_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [HCW-1:0] col_i,
   input  pat_e           sel_i,
   output logic [23:0]    rgb_o,
   output logic           ext_o
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [HCW-1:0] bar_q;
   logic [2:0]     bar_idx;
   logic [23:0]    rgb_d;

   always_comb begin
      bar_q   = col_i / HCW'(BAR_W);
      bar_idx = (bar_q > HCW'(7)) ? 3'd7 : bar_q[2:0];
      case (sel_i)
         PAT_BARS:  rgb_d = bar_rgb(bar_idx);
         PAT_RAMP:  rgb_d = {3{col_i[7:0]}};
         PAT_WHITE: rgb_d = 24'hFFFFFF;
         default:   rgb_d = 24'h000000;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rgb_o <= '0;
         ext_o <= 1'b1;
      end else begin
         rgb_o <= rgb_d;
         ext_o <= (sel_i == PAT_EXT);
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// 720p transmit timing generator: counters, sync/blank decode and a 2-stage aligned output pipe.
// Define VTG_PATTERN_EN to build the internal pattern generator and the pat_sel port.
module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           run,
`ifdef VTG_PATTERN_EN
   input  logic [1:0]     pat_sel,
`endif
   output logic           pix_req,
   output logic [HCW-1:0] req_col,
   output logic [VCW-1:0] req_row,
   input  logic [7:0]     pix_red,
   input  logic [7:0]     pix_green,
   input  logic [7:0]     pix_blue,
   output logic [7:0]     out_red,
   output logic [7:0]     out_green,
   output logic [7:0]     out_blue,
   output logic           out_hsync,
   output logic           out_vsync,
   output logic           out_blank,
   output logic           frame_start
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOT > 2048 || V_TOT > 1024) begin : g_bad_timing
      $error("video_timing_gen: totals exceed 11/10-bit counter range");
   end

   localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOT - 1);
   localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOT - 1);
   localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
   localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
   localparam logic [HCW-1:0] HS_BEG_C = HCW'(H_ACTIVE + H_FP);
   localparam logic [HCW-1:0] HS_END_C = HCW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCW-1:0] VS_BEG_C = VCW'(V_ACTIVE + V_FP);
   localparam logic [VCW-1:0] VS_END_C = VCW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HCW-1:0] h_cnt_q, h_cnt_d;
   logic [VCW-1:0] v_cnt_q, v_cnt_d;
   logic           active, hs0, vs0, fs0, past_hs;
   logic           blank1_q, hs1_q, vs1_q, fs1_q;
   logic [23:0]    src_rgb;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!run) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
         h_cnt_d = h_cnt_q + 1'b1;
      end
   end

   // vsync region is shifted so both edges land on the hsync leading edge
   always_comb begin
      active  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
      past_hs = (h_cnt_q >= HS_BEG_C);
      hs0     = run && past_hs && (h_cnt_q < HS_END_C);
      vs0     = run && (((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C) && past_hs) ||
                        ((v_cnt_q > VS_BEG_C) && (v_cnt_q <= VS_END_C) && !past_hs));
      fs0     = run && (h_cnt_q == '0) && (v_cnt_q == '0);
      pix_req = run && active;
      req_col = pix_req ? h_cnt_q : '0;
      req_row = pix_req ? v_cnt_q : '0;
   end

`ifdef VTG_PATTERN_EN
   pat_e        pat_q, pat_cur;
   logic [23:0] pat_rgb;
   logic        pat_ext;

   // Selection only changes while the counters sit at the frame origin.
   assign pat_cur = ((h_cnt_q == '0) && (v_cnt_q == '0)) ? pat_e'(pat_sel) : pat_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) pat_q <= PAT_EXT;
      else       pat_q <= pat_cur;
   end

   vtg_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
      .clk   (clk),
      .rstn  (rstn),
      .col_i (req_col),
      .sel_i (pat_cur),
      .rgb_o (pat_rgb),
      .ext_o (pat_ext)
   );

   assign src_rgb = pat_ext ? {pix_red, pix_green, pix_blue} : pat_rgb;
`else
   assign src_rgb = {pix_red, pix_green, pix_blue};
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         blank1_q    <= 1'b1;
         hs1_q       <= 1'b0;
         vs1_q       <= 1'b0;
         fs1_q       <= 1'b0;
         out_red     <= '0;
         out_green   <= '0;
         out_blue    <= '0;
         out_blank   <= 1'b1;
         out_hsync   <= ~HS_POL;
         out_vsync   <= ~VS_POL;
         frame_start <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         blank1_q    <= !pix_req;
         hs1_q       <= hs0;
         vs1_q       <= vs0;
         fs1_q       <= fs0;
         out_red     <= blank1_q ? 8'h00 : src_rgb[23:16];
         out_green   <= blank1_q ? 8'h00 : src_rgb[15:8];
         out_blue    <= blank1_q ? 8'h00 : src_rgb[7:0];
         out_blank   <= blank1_q;
         out_hsync   <= hs1_q ? HS_POL : ~HS_POL;
         out_vsync   <= vs1_q ? VS_POL : ~VS_POL;
         frame_start <= fs1_q;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: one full-size 720p instance for line timing and data latency, one shrunken
// instance (28 x 13 totals) for frame/vsync timing, run drop/resume and async reset.
module tb_video_timing_gen;

   logic clk = 1'b0;
   logic rstn;
   logic run;
   logic [1:0] pat_sel;

   logic        hd_req, sm_req;
   logic [10:0] hd_col, sm_col;
   logic [9:0]  hd_row, sm_row;
   logic [7:0]  hd_pr, hd_pg, hd_pb, sm_pr, sm_pg, sm_pb;
   logic [7:0]  hd_or, hd_og, hd_ob, sm_or, sm_og, sm_ob;
   logic        hd_hs, hd_vs, hd_bl, hd_fs, sm_hs, sm_vs, sm_bl, sm_fs;

   int checks = 0;
   int errors = 0;
   int pos;

   always #5 clk = ~clk;

   // Upstream store model: 1-cycle read latency, R=col, G=row, B=~col.
   always @(posedge clk) begin
      hd_pr <= hd_col[7:0];
      hd_pg <= hd_row[7:0];
      hd_pb <= ~hd_col[7:0];
      sm_pr <= sm_col[7:0];
      sm_pg <= sm_row[7:0];
      sm_pb <= ~sm_col[7:0];
   end

   video_timing_gen u_hd (
      .clk(clk), .rstn(rstn), .run(run),
`ifdef VTG_PATTERN_EN
      .pat_sel(pat_sel),
`endif
      .pix_req(hd_req), .req_col(hd_col), .req_row(hd_row),
      .pix_red(hd_pr), .pix_green(hd_pg), .pix_blue(hd_pb),
      .out_red(hd_or), .out_green(hd_og), .out_blue(hd_ob),
      .out_hsync(hd_hs), .out_vsync(hd_vs), .out_blank(hd_bl), .frame_start(hd_fs)
   );

   video_timing_gen #(
      .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) u_sm (
      .clk(clk), .rstn(rstn), .run(run),
`ifdef VTG_PATTERN_EN
      .pat_sel(pat_sel),
`endif
      .pix_req(sm_req), .req_col(sm_col), .req_row(sm_row),
      .pix_red(sm_pr), .pix_green(sm_pg), .pix_blue(sm_pb),
      .out_red(sm_or), .out_green(sm_og), .out_blue(sm_ob),
      .out_hsync(sm_hs), .out_vsync(sm_vs), .out_blank(sm_bl), .frame_start(sm_fs)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      pos++;
   endtask

   // Output pixel index relative to the run rising edge; bounded by the target itself.
   task automatic goto(input int p);
      while (pos < p) tick();
   endtask

   task automatic start_run();
      @(posedge clk);
      #1;
      run = 1'b1;
      pos = -2;
   endtask

   initial begin
      rstn    = 1'b0;
      run     = 1'b0;
      pat_sel = 2'd0;
      pos     = 0;
      #12;
      check("rst_blank", 32'(hd_bl), 32'd1);
      check("rst_hsync", 32'(hd_hs), 32'd0);
      check("rst_vsync", 32'(sm_vs), 32'd0);
      check("rst_fs",    32'(hd_fs), 32'd0);
      check("rst_rgb",   32'({hd_or, hd_og, hd_ob}), 32'h0);
      check("rst_req",   32'(hd_req), 32'd0);
      rstn = 1'b1;
      tick(); tick();
      check("idle_blank", 32'(sm_bl), 32'd1);
      check("idle_req",   32'(sm_req), 32'd0);

      start_run();
      #1;
      check("run_req",     32'(hd_req), 32'd1);
      check("run_req_col", 32'(hd_col), 32'd0);
      tick();
      check("pre_blank", 32'(hd_bl), 32'd1);
      check("pre_fs",    32'(hd_fs), 32'd0);
      tick();
      check("p0_fs",    32'(hd_fs), 32'd1);
      check("p0_blank", 32'(hd_bl), 32'd0);
      check("p0_rgb",   32'({hd_or, hd_og, hd_ob}), 32'h0000FF);
      check("p0_sm_fs", 32'(sm_fs), 32'd1);
      goto(1);
      check("p1_red", 32'(hd_or), 32'h01);
      check("p1_fs",  32'(hd_fs), 32'd0);
      goto(15);
      check("sm_c15_red", 32'(sm_or), 32'h0F);
      goto(16);
      check("sm_c16_blank", 32'(sm_bl), 32'd1);
      check("sm_c16_red",   32'(sm_or), 32'h00);
      goto(18);
      check("sm_hs_pre", 32'(sm_hs), 32'd0);
      goto(19);
      check("sm_hs_lead", 32'(sm_hs), 32'd1);
      goto(22);
      check("sm_hs_last", 32'(sm_hs), 32'd1);
      goto(23);
      check("sm_hs_trail", 32'(sm_hs), 32'd0);
      goto(89);
      check("sm_r3c5", 32'({sm_or, sm_og}), 32'h0503);
      goto(242);
      check("sm_vs_pre", 32'(sm_vs), 32'd0);
      goto(243);
      check("sm_vs_lead", 32'(sm_vs), 32'd1);
      goto(252);
      check("sm_vs_mid", 32'({sm_vs, sm_hs}), 32'b10);
      goto(255);
      check("hd_c255_red", 32'(hd_or), 32'hFF);
      goto(298);
      check("sm_vs_last", 32'(sm_vs), 32'd1);
      goto(299);
      check("sm_vs_trail", 32'(sm_vs), 32'd0);
      goto(364);
      check("sm_f2_fs", 32'({sm_fs, sm_bl}), 32'b10);
      goto(1279);
      check("hd_c1279", 32'({hd_bl, hd_or}), 32'h0FF);
      goto(1280);
      check("hd_c1280", 32'({hd_bl, hd_or}), 32'h100);
      goto(1389);
      check("hd_hs_pre", 32'(hd_hs), 32'd0);
      goto(1390);
      check("hd_hs_lead", 32'({hd_hs, hd_vs}), 32'b10);
      goto(1429);
      check("hd_hs_last", 32'(hd_hs), 32'd1);
      goto(1430);
      check("hd_hs_trail", 32'(hd_hs), 32'd0);
      goto(1650);
      check("hd_r1c0", 32'({hd_fs, hd_bl, hd_or, hd_og}), 32'h0001);
      goto(3040);
      check("hd_hs_period", 32'(hd_hs), 32'd1);

      // small instance counters sit at row 2 col 5 here
      goto(3335);
      run = 1'b0;
      tick();
      check("drop_req",   32'({sm_req, sm_col}), 32'h0);
      check("drop_drain", 32'({sm_bl, sm_or, sm_og}), 32'h00402);
      tick();
      check("drop_blank", 32'({sm_bl, sm_or, sm_hs}), 32'h200);
      tick(); tick(); tick();
      check("hold_out", 32'({sm_bl, sm_fs, sm_vs}), 32'b100);
      check("hold_req", 32'(sm_req), 32'd0);
      run = 1'b1;
      pos = -2;
      #1;
      check("resume_req", 32'({sm_req, sm_row, sm_col}), 32'h200000);
      goto(0);
      check("resume_fs",  32'({sm_fs, sm_bl}), 32'b10);
      check("resume_rgb", 32'({sm_or, sm_og}), 32'h0000);
      goto(17);
      check("resume_r0c17", 32'({sm_bl, sm_og}), 32'h100);

      goto(30);
      rstn = 1'b0;
      #1;
      check("arst_blank", 32'({hd_bl, hd_fs, hd_or}), 32'h200);
      check("arst_sync",  32'({sm_hs, sm_vs, sm_bl}), 32'b001);

`ifdef VTG_PATTERN_EN
      run     = 1'b0;
      pat_sel = 2'd1;
      #20;
      rstn = 1'b1;
      start_run();
      goto(0);
      check("pat_white", 32'({hd_or, hd_og, hd_ob}), 32'hFFFFFF);
      pat_sel = 2'd2;
      goto(5);
      check("pat_sm_cyan", 32'({sm_or, sm_og, sm_ob}), 32'h00FFFF);
      goto(160);
      check("pat_yellow", 32'({hd_or, hd_og, hd_ob}), 32'hFFFF00);
      goto(369);
      check("pat_ramp", 32'({sm_or, sm_og, sm_ob}), 32'h050505);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
